norm_arbiter: RTL

Multi-cycle normalizer that shares one leading-zero counter and barrel shifter among several requesters, e.g. the X and Y ray-direction reciprocal paths. Each requester hands over a WIDTH-bit operand with valid/ready. The block returns the operand left-normalized (MSB set), the shift amount, a zero flag and the requester's index. Results feed the reciprocal lookup/Newton stage, which consumes them with valid/ready.

---
 rtl/norm_arbiter_pkg.sv | 37 +++
 rtl/norm_arbiter_lzc.sv | 21 ++
 rtl/norm_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/norm_arbiter_pkg.sv
// Shared definitions for the normalizer arbiter: FSM encoding, count width
// and the requester grant search used by both arbitration modes.
package norm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Leading-zero count width; holds 0..64 for the widest legal operand.
    localparam int LZC_W   = 7;

    // Largest requester count the grant search has to cover.
    localparam int MAX_REQ = 8;

    // First set bit of valid, scanning upward from start and wrapping at nreq.
    // Fixed priority passes start = 0; round-robin passes last_granted + 1.
    function automatic logic [2:0] grant_idx(input logic [MAX_REQ-1:0] valid,
                                             input logic [2:0]         start,
                                             input int                 nreq);
        logic [2:0] idx;
        logic       found;
        int         pos;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = (int'(start) + k) % nreq;
            if (!found && (k < nreq) && valid[pos]) begin
                idx   = 3'(pos);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/norm_arbiter_lzc.sv
// Leading-zero counter: number of zero bits above the most significant set
// bit; an all-zero input yields WIDTH.
module norm_arbiter_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt
);

    // Scan upward so the highest set bit is the last one to overwrite the count.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_arbiter.sv
// Shared left-normalizer for several requesters. One operand is accepted in
// IDLE, normalized in CALC and presented in HOLD until taken downstream.
// Build option: define NORM_ARBITER_RR_EN for round-robin arbitration;
// without it the lowest-indexed valid requester always wins.
module norm_arbiter
    import norm_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDW-1:0]        out_id,
    output logic [WIDTH-1:0]      out_data,
    output logic [LZC_W-1:0]      out_shift,
    output logic                  out_zero
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_operand;
    logic [IDW-1:0]     r_id;
    logic [WIDTH-1:0]   r_out_data;
    logic [LZC_W-1:0]   r_out_shift;
    logic               r_out_zero;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_ops [NREQ];
    logic [2:0]         w_start;
    logic [IDW-1:0]     w_sel;
    logic               w_accept;
    logic [LZC_W-1:0]   w_cnt;
    logic [WIDTH-1:0]   w_shifted;

    // Split the flat operand bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_ops[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef NORM_ARBITER_RR_EN
    logic [IDW-1:0] r_last;

    // Search begins one past the last granted requester, wrapping at NREQ.
    always_comb begin
        w_start = (r_last == IDW'(NREQ - 1)) ? 3'd0 : (3'(r_last) + 3'd1);
    end

    // Remember the most recent grant; moves only when an operand is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_last <= w_sel;
        end
    end
`else
    // Fixed priority: always start the search at requester 0.
    always_comb begin
        w_start = 3'd0;
    end
`endif

    // Pick the winner and raise its ready strobe only while idle; the strobe is
    // forced low during reset so no requester sees a phantom accept.
    always_comb begin
        w_sel     = IDW'(grant_idx(MAX_REQ'(req_valid), w_start, NREQ));
        w_accept  = reset_n && (r_state == ST_IDLE) && (|req_valid);
        req_ready = w_accept ? (NREQ'(1) << w_sel) : '0;
    end

    norm_arbiter_lzc #(
        .WIDTH (WIDTH),
        .CNT_W (LZC_W)
    ) u_lzc (
        .i_data (r_operand),
        .o_cnt  (w_cnt)
    );

    // A count of WIDTH means a zero operand; force zero rather than rely on
    // shift semantics at the full width.
    always_comb begin
        w_shifted = (w_cnt >= LZC_W'(WIDTH)) ? '0 : (r_operand << w_cnt);
    end

    // Accept / normalize / hold sequencer with all result outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_operand   <= '0;
            r_id        <= '0;
            r_out_data  <= '0;
            r_out_shift <= '0;
            r_out_zero  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_operand <= w_ops[w_sel];
                        r_id      <= w_sel;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_out_data  <= w_shifted;
                    r_out_shift <= w_cnt;
                    r_out_zero  <= (w_cnt == LZC_W'(WIDTH));
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_id;
    assign out_data  = r_out_data;
    assign out_shift = r_out_shift;
    assign out_zero  = r_out_zero;

endmodule
